io_bus_controller: RTL and testbench

- Memory-mapped I/O controller between the single-cycle CPU's data-memory port, the data RAM and the board I/O: sw[9:0], key[3:1], hex5..hex0 and led[9:0].
- Decodes each CPU data access and steers it either to data memory or to the I/O register file.
- Synchronises the switches, debounces the keys, latches key-press events and drives the seven-segment displays and LEDs from registers.

---
 rtl/io_bus_controller.sv | 168 ++++++++++++++++
 tb/tb_io_bus_controller.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_controller.sv
// Memory-mapped I/O controller: splits CPU data accesses between data RAM and a small
// register file for switches, debounced keys with sticky press events, LEDs and 7-seg displays.
module io_bus_controller #(
    parameter int          DEBOUNCE_CYCLES = 500000,
    parameter logic [31:0] IO_BASE         = 32'hFFFF_F000
) (
    input  logic        clock,
    input  logic        resetn,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic [31:0] dmem_rdata,
    output logic        dmem_we,
    output logic [31:0] rdata,
    input  logic [9:0]  sw,
    input  logic [2:0]  key,
    output logic [6:0]  hex5,
    output logic [6:0]  hex4,
    output logic [6:0]  hex3,
    output logic [6:0]  hex2,
    output logic [6:0]  hex1,
    output logic [6:0]  hex0,
    output logic [9:0]  led
);

    localparam int                CNT_W   = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [9:0] OFF_SW        = 10'h000;
    localparam logic [9:0] OFF_KEY_STATE = 10'h001;
    localparam logic [9:0] OFF_KEY_EVENT = 10'h002;
    localparam logic [9:0] OFF_LED       = 10'h003;
    localparam logic [9:0] OFF_HEX_VAL   = 10'h004;
    localparam logic [9:0] OFF_HEX_BLANK = 10'h005;

    logic        ioSel;
    logic        wrEn;
    logic [9:0]  offset;
    logic [31:0] ioRead;

    logic [9:0]  swMeta_q;
    logic [9:0]  swSync_q;
    logic [2:0]  keyMeta_q;
    logic [2:0]  keySync_q;
    logic [2:0]  keyDb_q;
    logic [2:0]  keyDb_d;
    logic [2:0]  keyEvt_q;
    logic [2:0]  keyEvt_d;
    logic [2:0]  evtClr;
    logic [CNT_W-1:0] cnt_q [3];
    logic [CNT_W-1:0] cnt_d [3];

    logic [9:0]  ledReg_q;
    logic [23:0] hexVal_q;
    logic [5:0]  hexBlank_q;

    logic        unusedBits;

    assign ioSel      = (addr[31:12] == IO_BASE[31:12]);
    assign offset     = addr[11:2];
    assign wrEn       = we & ioSel;
    assign dmem_we    = we & ~ioSel;
    assign rdata      = ioSel ? ioRead : dmem_rdata;
    assign unusedBits = ^{addr[1:0], wdata[31:24]};

    always_comb begin
        ioRead = 32'h0;
        case (offset)
            OFF_SW:        ioRead = {22'b0, swSync_q};
            OFF_KEY_STATE: ioRead = {29'b0, keyDb_q};
            OFF_KEY_EVENT: ioRead = {29'b0, keyEvt_q};
            OFF_LED:       ioRead = {22'b0, ledReg_q};
            OFF_HEX_VAL:   ioRead = {8'b0, hexVal_q};
            OFF_HEX_BLANK: ioRead = {26'b0, hexBlank_q};
            default:       ioRead = 32'h0;
        endcase
    end

    // A key level is accepted only after staying different from keyDb for the full count.
    always_comb begin
        keyDb_d = keyDb_q;
        for (int i = 0; i < 3; i++) begin
            cnt_d[i] = cnt_q[i];
            if (keySync_q[i] == keyDb_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_MAX) begin
                keyDb_d[i] = keySync_q[i];
                cnt_d[i]   = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end
    end

    // Press detection is applied after the clear so a same-edge press survives a W1C write.
    always_comb begin
        evtClr   = (wrEn && offset == OFF_KEY_EVENT) ? wdata[2:0] : 3'b0;
        keyEvt_d = (keyEvt_q & ~evtClr) | (keyDb_d & ~keyDb_q);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            swMeta_q  <= '0;
            swSync_q  <= '0;
            keyMeta_q <= '0;
            keySync_q <= '0;
            keyDb_q   <= '0;
            keyEvt_q  <= '0;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= '0;
            end
        end else begin
            swMeta_q  <= sw;
            swSync_q  <= swMeta_q;
            keyMeta_q <= ~key;
            keySync_q <= keyMeta_q;
            keyDb_q   <= keyDb_d;
            keyEvt_q  <= keyEvt_d;
            for (int i = 0; i < 3; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ledReg_q   <= '0;
            hexVal_q   <= '0;
            hexBlank_q <= 6'h3F;
        end else if (wrEn) begin
            if (offset == OFF_LED)       ledReg_q   <= wdata[9:0];
            if (offset == OFF_HEX_VAL)   hexVal_q   <= wdata[23:0];
            if (offset == OFF_HEX_BLANK) hexBlank_q <= wdata[5:0];
        end
    end

    function automatic logic [6:0] segEncode(input logic [3:0] v, input logic blank);
        logic [6:0] seg;
        case (v)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            default: seg = 7'b0001110;
        endcase
        return blank ? 7'b1111111 : seg;
    endfunction

    assign hex0 = segEncode(hexVal_q[3:0],   hexBlank_q[0]);
    assign hex1 = segEncode(hexVal_q[7:4],   hexBlank_q[1]);
    assign hex2 = segEncode(hexVal_q[11:8],  hexBlank_q[2]);
    assign hex3 = segEncode(hexVal_q[15:12], hexBlank_q[3]);
    assign hex4 = segEncode(hexVal_q[19:16], hexBlank_q[4]);
    assign hex5 = segEncode(hexVal_q[23:20], hexBlank_q[5]);
    assign led  = ledReg_q;

endmodule

// File: tb/tb_io_bus_controller.sv
// Directed bench for io_bus_controller with a short debounce count; expected values are
// hand-derived from the register map, synchroniser depth and debounce timing.
module tb_io_bus_controller;

    localparam logic [31:0] A_SW        = 32'hFFFF_F000;
    localparam logic [31:0] A_KEY_STATE = 32'hFFFF_F004;
    localparam logic [31:0] A_KEY_EVENT = 32'hFFFF_F008;
    localparam logic [31:0] A_LED       = 32'hFFFF_F00C;
    localparam logic [31:0] A_HEX_VAL   = 32'hFFFF_F010;
    localparam logic [31:0] A_HEX_BLANK = 32'hFFFF_F014;

    logic        clock = 1'b0;
    logic        resetn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic [31:0] dmem_rdata;
    logic        dmem_we;
    logic [31:0] rdata;
    logic [9:0]  sw;
    logic [2:0]  key;
    logic [6:0]  hex5, hex4, hex3, hex2, hex1, hex0;
    logic [9:0]  led;

    int compared   = 0;
    int mismatched = 0;

    logic [6:0] segTable [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    io_bus_controller #(.DEBOUNCE_CYCLES(4), .IO_BASE(32'hFFFF_F000)) dut (
        .clock(clock), .resetn(resetn), .addr(addr), .wdata(wdata), .we(we),
        .dmem_rdata(dmem_rdata), .dmem_we(dmem_we), .rdata(rdata),
        .sw(sw), .key(key),
        .hex5(hex5), .hex4(hex4), .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
        .led(led)
    );

    always #50 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d, input logic w);
        addr  = a;
        wdata = d;
        we    = w;
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
        applyStimulus(a, d, 1'b1);
        tick();
        applyStimulus(a, 32'h0, 1'b0);
    endtask

    task automatic checkRead(input string tag, input logic [31:0] a, input logic [31:0] exp);
        applyStimulus(a, 32'h0, 1'b0);
        #1;
        checkOutput(tag, rdata, exp);
    endtask

    initial begin
        resetn     = 1'b0;
        sw         = 10'h0;
        key        = 3'b111;
        dmem_rdata = 32'hDEAD_BEEF;
        applyStimulus(32'h0, 32'h0, 1'b0);
        tick(2);

        // Reset state
        checkOutput("rstHex0", hex0, 7'h7F);
        checkOutput("rstHex5", hex5, 7'h7F);
        checkOutput("rstLed", led, 10'h0);
        resetn = 1'b1;
        tick();
        checkRead("rstLedReg", A_LED, 32'h0);
        checkRead("rstHexVal", A_HEX_VAL, 32'h0);
        checkRead("rstHexBlank", A_HEX_BLANK, 32'h3F);
        checkRead("rstKeyEvt", A_KEY_EVENT, 32'h0);
        checkRead("rstKeyState", A_KEY_STATE, 32'h0);

        // Decode and steering
        applyStimulus(32'h0000_0040, 32'h1234, 1'b1);
        #1 checkOutput("dmemWeRam", dmem_we, 1'b1);
        tick();
        applyStimulus(A_LED, 32'h3FF, 1'b1);
        #1 checkOutput("dmemWeIo", dmem_we, 1'b0);
        tick();
        applyStimulus(A_LED, 32'h0, 1'b0);
        #1 checkOutput("ledOut", led, 10'h3FF);
        dmem_rdata = 32'hCAFE_F00D;
        checkRead("ramLoad", 32'h0000_0040, 32'hCAFE_F00D);
        checkRead("belowWindow", 32'hFFFF_EFFC, 32'hCAFE_F00D);
        applyStimulus(32'hFFFF_EFFC, 32'h1, 1'b1);
        #1 checkOutput("belowWindowWe", dmem_we, 1'b1);
        checkRead("ledByteOff", 32'hFFFF_F00F, 32'h3FF);
        busWrite(32'hFFFF_F018, 32'hFFFF_FFFF);
        checkRead("unmapped018", 32'hFFFF_F018, 32'h0);
        checkRead("unmappedFFC", 32'hFFFF_FFFC, 32'h0);
        checkRead("ledAfterUnmapped", A_LED, 32'h3FF);

        // Seven-segment
        busWrite(A_HEX_BLANK, 32'h0);
        busWrite(A_HEX_VAL, 32'h00A5F0);
        checkOutput("hexA5F0_0", hex0, 7'h40);
        checkOutput("hexA5F0_1", hex1, 7'h0E);
        checkOutput("hexA5F0_2", hex2, 7'h12);
        checkOutput("hexA5F0_3", hex3, 7'h08);
        checkOutput("hexA5F0_4", hex4, 7'h40);
        checkOutput("hexA5F0_5", hex5, 7'h40);
        busWrite(A_HEX_BLANK, 32'h30);
        checkOutput("blank5", hex5, 7'h7F);
        checkOutput("blank4", hex4, 7'h7F);
        checkOutput("blankKeep3", hex3, 7'h08);
        busWrite(A_HEX_BLANK, 32'h0);
        for (int d = 0; d < 16; d++) begin
            logic [3:0] n;
            n = d[3:0];
            busWrite(A_HEX_VAL, {8'h0, n, n, n, n, n, n});
            checkOutput($sformatf("seg%0d_hex0", d), hex0, segTable[d]);
            checkOutput($sformatf("seg%0d_hex5", d), hex5, segTable[d]);
        end
        busWrite(A_HEX_VAL, 32'hFF12_3456);
        checkRead("hexValTrunc", A_HEX_VAL, 32'h0012_3456);
        busWrite(A_HEX_BLANK, 32'hFFFF_FF8A);
        checkRead("hexBlankTrunc", A_HEX_BLANK, 32'h0A);

        // Switch synchroniser
        sw = 10'b1010101010;
        tick();
        checkRead("swOneEdge", A_SW, 32'h0);
        tick();
        checkRead("swTwoEdges", A_SW, 32'h2AA);
        sw = ~sw;
        tick();
        checkRead("swInvOneEdge", A_SW, 32'h2AA);
        tick();
        checkRead("swInvTwoEdges", A_SW, 32'h155);

        // Short glitch on key1
        key = 3'b110;
        tick(3);
        key = 3'b111;
        tick(8);
        checkRead("glitchState", A_KEY_STATE, 32'h0);
        checkRead("glitchEvt", A_KEY_EVENT, 32'h0);

        // Held key1 press
        key = 3'b110;
        tick(5);
        checkRead("pressEdge5State", A_KEY_STATE, 32'h0);
        checkRead("pressEdge5Evt", A_KEY_EVENT, 32'h0);
        tick();
        checkRead("pressEdge6State", A_KEY_STATE, 32'h1);
        checkRead("pressEdge6Evt", A_KEY_EVENT, 32'h1);
        tick(4);
        key = 3'b111;
        tick(8);
        checkRead("releaseState", A_KEY_STATE, 32'h0);
        checkRead("releaseEvt", A_KEY_EVENT, 32'h1);
        checkRead("readNoClear", A_KEY_EVENT, 32'h1);
        busWrite(A_KEY_EVENT, 32'h0);
        checkRead("writeZeroKeeps", A_KEY_EVENT, 32'h1);
        busWrite(A_KEY_EVENT, 32'h1);
        checkRead("w1cClears", A_KEY_EVENT, 32'h0);

        // Key2 accepted on the same edge as a clear write
        key = 3'b101;
        tick(5);
        busWrite(A_KEY_EVENT, 32'h7);
        checkRead("setWinsEvt", A_KEY_EVENT, 32'h2);
        checkRead("setWinsState", A_KEY_STATE, 32'h2);

        // Reset in the middle of a key3 debounce, keys 2 and 3 held throughout
        key = 3'b001;
        tick(3);
        resetn = 1'b0;
        #1;
        checkRead("midRstEvt", A_KEY_EVENT, 32'h0);
        checkRead("midRstState", A_KEY_STATE, 32'h0);
        checkRead("midRstSw", A_SW, 32'h0);
        checkOutput("midRstLed", led, 10'h0);
        checkOutput("midRstHex0", hex0, 7'h7F);
        applyStimulus(32'h0000_0040, 32'h5, 1'b1);
        #1 checkOutput("midRstDmemWe", dmem_we, 1'b1);
        applyStimulus(32'h0, 32'h0, 1'b0);
        tick();
        resetn = 1'b1;
        tick(5);
        checkRead("heldEdge5Evt", A_KEY_EVENT, 32'h0);
        tick();
        checkRead("heldEdge6Evt", A_KEY_EVENT, 32'h6);
        checkRead("heldEdge6State", A_KEY_STATE, 32'h6);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
